rgbcry: RTL
===========

// Module: rgbcry
// PURPOSE
//  Pixel encoder: packs 24-bit RGB into a 16-bit Jaguar CRY word {c[7:0],i[7:0]}, or into a 16-bit RGB word.
//  It is the inverse of the TOM CRY->RGB pixel decoder: cry[15:8] is chroma, cry[7:0] is intensity.
//  Used on the host/bus side (blitter fill colour, capture path) so software can write 24-bit colours.
//  Chroma comes from an external 2^(3*IDX_BITS) x 8 RGB->CRY chroma ROM, read through a request port.
// PARAMETERS
//  IDX_BITS  5  normalized bits per channel used as ROM index; rom_addr is 3*IDX_BITS wide
//  ROM_LAT   1  ROM read latency in cycles, from rom_rd to rom_data valid (1..3)
// PORTS
//  sys_clk    in   1           system clock, all state on rising edge
//  reset      in   1           asynchronous, active-high reset
//  in_valid   in   1           input pixel valid
//  in_ready   out  1           encoder idle, accepts a pixel
//  r_in       in   8           red
//  g_in       in   8           green
//  b_in       in   8           blue
//  rgb        in   1           1 = RGB16 packing, 0 = CRY encoding; sampled on accept
//  out_valid  out  1           cry valid; held until out_ready
//  out_ready  in   1           consumer accepts cry
//  cry        out  16          encoded pixel
//  rom_rd     out  1           one-cycle chroma ROM read strobe
//  rom_addr   out  3*IDX_BITS  ROM index {rn,gn,bn}
//  rom_data   in   8           chroma byte, valid ROM_LAT cycles after rom_rd
// BEHAVIOUR
//  Reset (async, active-high):
//   - state=IDLE, in_ready=1, out_valid=0, cry=0, rom_rd=0, rom_addr=0.
//   - Reset mid-operation abandons the pixel; no rom_rd follows.
//   - A late rom_data is ignored.
//  Single outstanding pixel: in_ready=1 only in IDLE.
//   - Accept = in_valid & in_ready. R/G/B/rgb are registered.
//   - I = max(R,G,B) is registered on accept.
//  FSM IDLE -> DIV -> ADDR -> ROMW -> OUT -> IDLE, with shortcuts from IDLE:
//   - rgb=1 on accept: go to OUT. cry = {R[7:3], B[7:3], G[7:2]}; valid in cycle after accept.
//   - rgb=0 and I==0 (black): go to OUT. cry = 16'h0000; no ROM read.
//   - otherwise: go to DIV.
//  DIV, 9 cycles, restoring division, one quotient bit per cycle, all three channels in parallel:
//   - Xn = floor(X*256/I), 9-bit quotient.
//   - Saturate to 255 (X==I gives 256 -> 255).
//   - Keep Xn[7:8-IDX_BITS].
//  ADDR, 1 cycle: rom_rd=1, rom_addr={rn,gn,bn}, red in the MSBs.
//   - rom_addr holds its value until the next ADDR.
//  ROMW, ROM_LAT cycles: on the last of these, capture cry = {rom_data, I}.
//  OUT: out_valid=1; cry stable while out_ready=0.
//   - out_valid & out_ready: go to IDLE next cycle; out_valid=0, cry holds.
//   - No new accept in the same cycle as the handoff.
//  Latency, accept edge = cycle 0:
//   - CRY path: out_valid from cycle 11+ROM_LAT (12 at default).
//   - RGB/black path: out_valid from cycle 1.
//  in_valid while busy is ignored; the source must hold it until accepted.
// TESTING
//  1 Reset asserted mid-DIV -> same cycle: in_ready=1, out_valid=0, cry=0; no rom_rd ever; next pixel encodes correctly.
//  2 rgb=0, R=G=B=0 -> out_valid at cycle 1, cry=0x0000, rom_rd never asserted.
//  3 rgb=0, R=FF G=00 B=00 -> rom_rd at cycle 10, rom_addr=15'h7C00; rom_data=F0 -> cry=0xF0FF at cycle 12.
//  4 rgb=0, R=40 G=20 B=10 -> I=40, rn=31 gn=16 bn=8, rom_addr=15'h7E08; rom_data=5A -> cry=0x5A40.
//  5 rgb=1, R=F8 G=FC B=08 -> cry=0xF87F at cycle 1, no rom_rd; decodes back to R=F8 G=FC B=08.
//  6 out_ready=0 for 5 cycles in OUT -> out_valid=1, cry stable, in_ready=0; accept resumes in the cycle after handoff.

Source files
------------

// File: rtl/rgbcry.sv
// RGB888 to Jaguar CRY / RGB16 pixel encoder.
// Intensity is the max channel; chroma is looked up from normalised channels via an external ROM.
module rgbcry #(
  parameter int unsigned IDX_BITS = 5,
  parameter int unsigned ROM_LAT  = 1
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              r_in,
  input  logic [7:0]              g_in,
  input  logic [7:0]              b_in,
  input  logic                    rgb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             cry,
  output logic                    rom_rd,
  output logic [3*IDX_BITS-1:0]   rom_addr,
  input  logic [7:0]              rom_data
);

  localparam int unsigned AW        = 3 * IDX_BITS;
  localparam int unsigned DIV_STEPS = 9;
  localparam int unsigned CW        = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_ADDR,
    S_ROMW,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [7:0]    i_q;
  logic [8:0]    rem_q   [3];
  logic [7:0]    quo_q   [3];
  logic [8:0]    rem_nxt [3];
  logic [8:0]    quo_nxt [3];
  logic          ge      [3];
  logic [7:0]    sat     [3];
  logic [IDX_BITS-1:0] idx [3];
  logic [AW-1:0] addr_nxt;
  logic [7:0]    max_rgb;
  logic          accept;
  logic          div_last;
  logic          rom_last;

  assign accept   = in_valid & in_ready;
  assign div_last = (cnt == CW'(DIV_STEPS - 1));
  assign rom_last = (cnt == CW'(ROM_LAT - 1));

  // Intensity of the incoming pixel
  always_comb begin
    max_rgb = r_in;
    if (g_in > max_rgb) max_rgb = g_in;
    if (b_in > max_rgb) max_rgb = b_in;
  end

  // One restoring-division step per channel; remainder is kept pre-doubled for the next bit
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      ge[ch]      = (rem_q[ch] >= {1'b0, i_q});
      rem_nxt[ch] = ge[ch] ? 9'((rem_q[ch] - {1'b0, i_q}) << 1) : 9'(rem_q[ch] << 1);
      quo_nxt[ch] = {quo_q[ch], ge[ch]};
      sat[ch]     = quo_nxt[ch][8] ? 8'hFF : quo_nxt[ch][7:0];
      idx[ch]     = IDX_BITS'(sat[ch] >> (8 - IDX_BITS));
    end
    addr_nxt = {idx[0], idx[1], idx[2]};
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (rgb || (max_rgb == 8'd0)) state_nxt = S_OUT;
          else                          state_nxt = S_DIV;
        end
      end
      S_DIV:  if (div_last) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_ROMW;
      S_ROMW: if (rom_last) state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cry       <= 16'h0000;
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      cnt       <= '0;
      i_q       <= 8'h00;
      for (int ch = 0; ch < 3; ch++) begin
        rem_q[ch] <= 9'h000;
        quo_q[ch] <= 8'h00;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            i_q      <= max_rgb;
            cnt      <= '0;
            rem_q[0] <= {1'b0, r_in};
            rem_q[1] <= {1'b0, g_in};
            rem_q[2] <= {1'b0, b_in};
            for (int ch = 0; ch < 3; ch++) quo_q[ch] <= 8'h00;
            if (rgb) begin
              cry       <= {r_in[7:3], b_in[7:3], g_in[7:2]};
              out_valid <= 1'b1;
            end else if (max_rgb == 8'd0) begin
              cry       <= 16'h0000;
              out_valid <= 1'b1;
            end
          end
        end
        S_DIV: begin
          for (int ch = 0; ch < 3; ch++) begin
            rem_q[ch] <= rem_nxt[ch];
            quo_q[ch] <= quo_nxt[ch][7:0];
          end
          if (div_last) begin
            cnt      <= '0;
            rom_rd   <= 1'b1;
            rom_addr <= addr_nxt;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ADDR: begin
          rom_rd <= 1'b0;
          cnt    <= '0;
        end
        S_ROMW: begin
          cnt <= cnt + CW'(1);
          if (rom_last) begin
            cry       <= {rom_data, i_q};
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          rom_rd    <= 1'b0;
        end
      endcase
    end
  end

endmodule
